// File: rtl/serial_tx_pkg.sv
// Shared state encoding and defaults for the MSB-first serialiser.
// The PAR encoding is reserved here even when the parity option is compiled out.
package serial_tx_pkg;

   localparam int WIDTH_DEFAULT = 8;
   localparam int STATE_W       = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   function automatic logic is_frame_state(input state_t s);
      return (s == SHIFT) || (s == PAR);
   endfunction

endpackage

// File: rtl/serial_tx_bitcnt.sv
// Data-bit index counter: runs 0..WIDTH-1 while enabled, wraps to 0 after the terminal count.
// Synchronous clear has priority over enable; o_tc flags the last data bit.
module serial_tx_bitcnt #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_clr,
   input  logic                     i_en,
   output logic [$clog2(WIDTH)-1:0] o_cnt,
   output logic                     o_tc
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc = (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = w_tc;

endmodule

// File: rtl/serial_tx.sv
// MSB-first serialiser, first bit one cycle after load; load_ready is low for the whole frame.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit (frame becomes WIDTH+1 cycles).
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last
);

   localparam int CW = $clog2(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic             r_load_ready;
   logic             r_ser_valid;
   logic             r_ser_last;
   logic             w_accept;
   logic             w_cnt_en;
   logic             w_tc;
   logic [CW-1:0]    w_cnt;
`ifdef SERIAL_TX_PARITY_EN
   logic             r_par;
`else
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

   // load_ready is only high in IDLE, so this is the handshake
   assign w_accept = load_valid && r_load_ready;
   assign w_cnt_en = (r_state == SHIFT);

   serial_tx_bitcnt #(
      .WIDTH (WIDTH)
   ) u_bitcnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_accept),
      .i_en  (w_cnt_en),
      .o_cnt (w_cnt),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_sr         <= '0;
         r_load_ready <= 1'b1;
         r_ser_valid  <= 1'b0;
         r_ser_last   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         r_par        <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state      <= SHIFT;
                  r_sr         <= load_data;
                  r_load_ready <= 1'b0;
                  r_ser_valid  <= 1'b1;
                  r_ser_last   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                  r_par        <= ^load_data;
`endif
               end
            end
            SHIFT: begin
               if (w_tc) begin
`ifdef SERIAL_TX_PARITY_EN
                  // parity rides in the MSB so ser_out stays a plain register tap
                  r_state    <= PAR;
                  r_sr       <= {r_par, {(WIDTH-1){1'b0}}};
                  r_ser_last <= 1'b1;
`else
                  r_state      <= IDLE;
                  r_sr         <= '0;
                  r_load_ready <= 1'b1;
                  r_ser_valid  <= 1'b0;
                  r_ser_last   <= 1'b0;
`endif
               end else begin
                  r_sr <= {r_sr[WIDTH-2:0], 1'b0};
`ifdef SERIAL_TX_PARITY_EN
                  r_ser_last <= 1'b0;
`else
                  r_ser_last <= (w_cnt == PENULT);
`endif
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
               r_state      <= IDLE;
               r_sr         <= '0;
               r_load_ready <= 1'b1;
               r_ser_valid  <= 1'b0;
               r_ser_last   <= 1'b0;
            end
`endif
            default: begin
               r_state      <= IDLE;
               r_sr         <= '0;
               r_load_ready <= 1'b1;
               r_ser_valid  <= 1'b0;
               r_ser_last   <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign ser_out    = r_sr[WIDTH-1];
   assign ser_valid  = r_ser_valid;
   assign ser_last   = r_ser_last;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: WIDTH=8 instance driven from a vector table into a bit scoreboard,
// plus hand sequences (back-to-back, reset abort, reset vs load) and a WIDTH=4 instance feeding a 1010 detector.
module tb_serial_tx;

   localparam int W  = 8;
   localparam int W4 = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int FL  = W + PAR_EN;
   localparam int FL4 = W4 + PAR_EN;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_valid;
   logic [W-1:0]  load_data;
   logic          load_ready;
   logic          ser_out;
   logic          ser_valid;
   logic          ser_last;
   logic          load_valid4;
   logic [W4-1:0] load_data4;
   logic          load_ready4;
   logic          ser_out4;
   logic          ser_valid4;
   logic          ser_last4;

   always #5 clk = ~clk;

   serial_tx #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .ser_last   (ser_last)
   );

   serial_tx #(.WIDTH(W4)) u_dut4 (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid4),
      .load_data  (load_data4),
      .load_ready (load_ready4),
      .ser_out    (ser_out4),
      .ser_valid  (ser_valid4),
      .ser_last   (ser_last4)
   );

   typedef struct packed {
      logic b;
      logic last;
   } sb_t;

   typedef struct {
      logic [7:0] data;
      logic [7:0] bits;   // transmission order, leftmost first
      logic       par;
   } vec_t;

   sb_t  q[$];
   sb_t  mon_e;
   bit   mon_en = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   vcnt;
   vec_t vecs[9];

   logic [3:0] hist4 = 4'b0;
   int det_cnt4 = 0;
   int bit_idx4 = 0;
   int last_idx4 = 0;
   int last_cnt4 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push_frame(input logic [7:0] bits, input logic par);
      for (int i = 7; i >= 0; i--) begin
         q.push_back('{b: bits[i], last: (PAR_EN == 0 && i == 0)});
      end
      if (PAR_EN != 0) q.push_back('{b: par, last: 1'b1});
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send8(input logic [7:0] d, input logic [7:0] bits, input logic par,
                        input bit keep_valid);
      int waited = 0;
      load_valid = 1'b1;
      load_data  = d;
      @(negedge clk);
      while (!load_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("accept_wait", load_ready, 1);
      @(posedge clk); #1;
      push_frame(bits, par);
      if (!keep_valid) load_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", q.size(), 0);
   endtask

   // Scoreboard: a valid bit is required exactly when an expected bit is pending.
   always @(negedge clk) begin
      if (mon_en) begin
         if (q.size() > 0) begin
            check("valid_in_frame", ser_valid, 1);
            if (ser_valid) begin
               mon_e = q.pop_front();
               check("ser_out", ser_out, mon_e.b);
               check("ser_last", ser_last, mon_e.last);
            end
         end else begin
            check("idle_valid", ser_valid, 0);
            check("idle_out", ser_out, 0);
            check("idle_last", ser_last, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (ser_valid4) begin
         hist4 = {hist4[2:0], ser_out4};
         bit_idx4++;
         if (hist4 == 4'b1010) det_cnt4++;
         if (ser_last4) begin
            last_idx4 = bit_idx4;
            last_cnt4++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{data: 8'hA5, bits: 8'b10100101, par: 1'b0};
      vecs[1] = '{data: 8'h07, bits: 8'b00000111, par: 1'b1};
      vecs[2] = '{data: 8'hFF, bits: 8'b11111111, par: 1'b0};
      vecs[3] = '{data: 8'h01, bits: 8'b00000001, par: 1'b1};
      vecs[4] = '{data: 8'h80, bits: 8'b10000000, par: 1'b1};
      vecs[5] = '{data: 8'h00, bits: 8'b00000000, par: 1'b0};
      vecs[6] = '{data: 8'h3C, bits: 8'b00111100, par: 1'b0};
      vecs[7] = '{data: 8'h96, bits: 8'b10010110, par: 1'b0};
      vecs[8] = '{data: 8'h0E, bits: 8'b00001110, par: 1'b1};

      reset       = 1'b1;
      load_valid  = 1'b0;
      load_data   = '0;
      load_valid4 = 1'b0;
      load_data4  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_load_ready", load_ready, 1);
      check("rst_ser_valid", ser_valid, 0);
      check("rst_ser_out", ser_out, 0);
      check("rst_ser_last", ser_last, 0);
      check("rst_load_ready4", load_ready4, 1);
      @(posedge clk); #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // vector table through the scoreboard
      for (int v = 0; v < 9; v++) begin
         send8(vecs[v].data, vecs[v].bits, vecs[v].par, 1'b0);
         wait_drain();
         @(negedge clk);
         check("ready_after_frame", load_ready, 1);
         @(posedge clk); #1;
      end

      // load_valid held high: AA then 55, data changed mid-frame must be ignored
      send8(8'hAA, 8'b10101010, 1'b0, 1'b1);
      load_data = 8'h55;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         check("b2b_frame1_valid", ser_valid, 1);
      end
      @(negedge clk);
      check("b2b_gap_valid", ser_valid, 0);
      check("b2b_gap_ready", load_ready, 1);
      @(posedge clk); #1;
      push_frame(8'b01010101, 1'b0);
      load_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         check("b2b_frame2_valid", ser_valid, 1);
      end
      @(negedge clk);
      check("b2b_end_valid", ser_valid, 0);
      @(posedge clk); #1;
      wait_drain();

      // reset while bit 4 is on the line
      send8(8'hC3, 8'b11000011, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete();
      @(negedge clk);
      check("abort_valid", ser_valid, 0);
      check("abort_out", ser_out, 0);
      check("abort_ready", load_ready, 1);
      vcnt = 0;
      repeat (FL + 2) begin
         @(negedge clk);
         if (ser_valid) vcnt++;
      end
      check("abort_no_more_bits", vcnt, 0);
      @(posedge clk); #1;

      // reset coincident with a load in IDLE
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      @(posedge clk); #1;
      reset      = 1'b0;
      load_valid = 1'b0;
      vcnt = 0;
      repeat (FL + 2) begin
         @(negedge clk);
         if (ser_valid) vcnt++;
      end
      check("rst_vs_load_no_frame", vcnt, 0);
      check("rst_vs_load_ready", load_ready, 1);
      @(posedge clk); #1;

      // WIDTH=4 into the 1010 detector
      load_valid4 = 1'b1;
      load_data4  = 4'b1010;
      vcnt = 0;
      @(negedge clk);
      while (!load_ready4 && vcnt < 20) begin
         @(negedge clk);
         vcnt++;
      end
      check("w4_accept_wait", load_ready4, 1);
      @(posedge clk); #1;
      load_valid4 = 1'b0;
      repeat (FL4 + 4) @(posedge clk);
      #1;
      check("w4_detect_once", det_cnt4, 1);
      check("w4_bits", bit_idx4, FL4);
      check("w4_last_pos", last_idx4, FL4);
      check("w4_last_once", last_cnt4, 1);

      wait_drain();
      check("final_queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits; the legal range is 2..32.
REQ-002 The block SHALL have the port clk  input  1  sole clock, with all state updated on the rising edge.
REQ-003 The block SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have the port load_valid  input  1  a payload is offered on load_data.
REQ-005 The block SHALL have the port load_data  input  WIDTH  payload to serialise, MSB first.
REQ-006 The block SHALL have the port load_ready  output  1  block can accept a payload this cycle.
REQ-007 The block SHALL have the port ser_out  output  1  serial bit line.
REQ-008 The block SHALL have the port ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-009 The block SHALL have the port ser_last  output  1  the current bit is the final bit of the frame.

Function
REQ-010 The state machine SHALL have the states IDLE, SHIFT and PAR; PAR exists only when PARITY_EN is defined.
REQ-011 load_ready SHALL be 1 in IDLE and 0 in every other state; it is a registered output and is not combinationally dependent on load_valid.
REQ-012 A payload SHALL be accepted on the rising edge where load_valid && load_ready; at that edge load_data is captured into a WIDTH-bit shift register and the state goes to SHIFT.
REQ-013 Latency SHALL be one cycle: the first bit (load_data[WIDTH-1]) is on ser_out, with ser_valid=1, in the cycle immediately after acceptance.
REQ-014 In SHIFT, the register SHALL shift left by one on each edge and ser_out SHALL equal the register MSB; exactly WIDTH bits are driven on WIDTH consecutive cycles, with no gaps.
REQ-015 The bit counter SHALL run from 0 to WIDTH-1; when it reaches WIDTH-1, the next state is PAR (with PARITY_EN) or IDLE (without it).
REQ-016 ser_last SHALL be 1 only during the final bit of the frame: the data bit WIDTH-1 without PARITY_EN, or the parity bit with PARITY_EN.
REQ-017 In IDLE, ser_out SHALL be 0, ser_valid SHALL be 0 and ser_last SHALL be 0.
REQ-018 load_valid or load_data activity while not in IDLE SHALL be ignored; the frame in flight is never corrupted or restarted.
REQ-019 The minimum frame spacing SHALL be one IDLE cycle, so back-to-back payloads are separated by exactly one cycle with ser_valid=0.
REQ-020 The parity SHALL be the XOR of all WIDTH bits captured at acceptance, which gives even parity over the data plus the parity bit.

Reset
REQ-021 When reset=1 at an edge, the next state SHALL be IDLE, the counter 0 and the shift register 0, with outputs load_ready=1, ser_out=0, ser_valid=0, ser_last=0.
REQ-022 reset SHALL take priority over a simultaneous load handshake; that payload is not accepted.
REQ-023 Reset during SHIFT or PAR SHALL abort the frame with no further frame bits, and the aborted frame SHALL never be resumed.

Configuration
REQ-024 With the macro SERIAL_TX_PARITY_EN defined, the PAR state SHALL be compiled in and one even-parity bit SHALL follow the data bits, giving a frame of WIDTH+1 cycles.
REQ-025 Without SERIAL_TX_PARITY_EN, the PAR state and parity logic SHALL be absent, the frame SHALL be exactly WIDTH cycles, and the port list SHALL be unchanged.

Structure
REQ-026 A shared package SHALL hold the state-encoding constants (IDLE=0, SHIFT=1, PAR=2, 2-bit encoding) and the WIDTH default.
REQ-027 The bit counter SHALL be a sub-module, serial_tx_bitcnt, with clear, enable and terminal-count output, and counter width SHALL be $clog2(WIDTH).
REQ-028 The block SHALL contain no other sub-modules, latches or combinational paths from inputs to outputs.

Verification
REQ-029 The bench SHALL cover: WIDTH=8, load 8'hA5 in IDLE -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after acceptance; ser_last on bit 8; with PARITY_EN a 9th bit 0.
REQ-030 The bench SHALL cover: WIDTH=8 with PARITY_EN, load 8'h07 -> data 0,0,0,0,0,1,1,1, then parity 1 with ser_last=1.
REQ-031 The bench SHALL cover: load_valid held high continuously with 8'hAA then 8'h55 -> two frames separated by exactly one cycle with ser_valid=0, and the second frame SHALL be 0,1,0,1,0,1,0,1.
REQ-032 The bench SHALL cover: reset=1 for one cycle during bit 4 of a frame -> next cycle ser_valid=0, ser_out=0, load_ready=1, and no remaining bits emitted.
REQ-033 The bench SHALL cover: reset=1 coincident with load_valid=1 in IDLE -> payload not accepted and ser_valid stays 0.
REQ-034 The bench SHALL cover: WIDTH=4, load 4'b1010, ser_out looped into a 1010 sequence detector -> the detector flags exactly once, and ser_last SHALL be on the 4th bit without PARITY_EN.
